// File: rtl/avalon_multi_interval_timer.sv
// Multi-channel Avalon-MM interval timer.
// Channel page (address[5]=0): {ch[4:2], reg[1:0]} -> STATUS, CONTROL, PERIOD, SNAP.
// Global page (address[5]=1): reg 0 GSTART (write mask), reg 1 IRQPEND (read-only).
// Each channel is a down-counter that reloads from PERIOD at terminal count.
module avalon_multi_interval_timer #(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 32,
  parameter int DEFAULT_PERIOD = 99999
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [5:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [NUM_CH-1:0] irq,
  output logic              irq_any
);

  localparam logic [CNT_W-1:0] LP_DEF = CNT_W'(DEFAULT_PERIOD);

  logic              w_wr;
  logic              w_glb;
  logic [2:0]        w_ch;
  logic [1:0]        w_reg;
  logic              w_gstart_wr;

  logic [NUM_CH-1:0] w_wr_stat;
  logic [NUM_CH-1:0] w_wr_ctrl;
  logic [NUM_CH-1:0] w_wr_per;
  logic [NUM_CH-1:0] w_wr_snap;
  logic [NUM_CH-1:0] w_start;
  logic [NUM_CH-1:0] w_stop;
  logic [NUM_CH-1:0] w_tc;

  logic [CNT_W-1:0]  r_cnt    [NUM_CH];
  logic [CNT_W-1:0]  r_period [NUM_CH];
  logic [CNT_W-1:0]  r_snap   [NUM_CH];
  logic [NUM_CH-1:0] r_run;
  logic [NUM_CH-1:0] r_to;
  logic [NUM_CH-1:0] r_ito;
  logic [NUM_CH-1:0] r_cont;
  logic [NUM_CH-1:0] r_fr;

  logic [31:0]       w_rd;
  logic [31:0]       r_readdata;

  assign w_wr        = chipselect & ~write_n;
  assign w_glb       = address[5];
  assign w_ch        = address[4:2];
  assign w_reg       = address[1:0];
  assign w_gstart_wr = w_wr & w_glb & (w_reg == 2'd0);

  // Per-channel write strobes; channels beyond NUM_CH never match and are ignored.
  always_comb begin
    w_wr_stat = '0;
    w_wr_ctrl = '0;
    w_wr_per  = '0;
    w_wr_snap = '0;
    w_start   = '0;
    w_stop    = '0;
    w_tc      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_wr && !w_glb && (w_ch == 3'(i))) begin
        w_wr_stat[i] = (w_reg == 2'd0);
        w_wr_ctrl[i] = (w_reg == 2'd1);
        w_wr_per[i]  = (w_reg == 2'd2);
        w_wr_snap[i] = (w_reg == 2'd3);
      end
      w_start[i] = (w_wr_ctrl[i] & writedata[2]) | (w_gstart_wr & writedata[i]);
      w_stop[i]  = w_wr_ctrl[i] & writedata[3];
      w_tc[i]    = r_run[i] & (r_cnt[i] == '0);
    end
  end

  // Channel state: counter, run/timeout flags, control bits, period and snapshot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i]    <= LP_DEF;
        r_period[i] <= LP_DEF;
        r_snap[i]   <= '0;
      end
      r_run  <= '0;
      r_to   <= '0;
      r_ito  <= '0;
      r_cont <= '0;
      r_fr   <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_wr_per[i]) r_period[i] <= writedata[CNT_W-1:0];
        r_fr[i] <= w_wr_per[i];

        // A one-shot channel parks at zero; restarting from idle reloads PERIOD
        // so the next event comes a full period later rather than immediately.
        if (r_fr[i] || (w_start[i] && !r_run[i])) begin
          r_cnt[i] <= r_period[i];
        end else if (r_run[i]) begin
          if (r_cnt[i] == '0) r_cnt[i] <= r_cont[i] ? r_period[i] : '0;
          else                r_cnt[i] <= r_cnt[i] - 1'b1;
        end

        if (w_start[i])                                         r_run[i] <= 1'b1;
        else if (w_stop[i] || r_fr[i] || (w_tc[i] && !r_cont[i])) r_run[i] <= 1'b0;

        // Setting beats clearing so a terminal event is never lost.
        if (w_tc[i])           r_to[i] <= 1'b1;
        else if (w_wr_stat[i]) r_to[i] <= 1'b0;

        if (w_wr_ctrl[i]) begin
          r_ito[i]  <= writedata[0];
          r_cont[i] <= writedata[1];
        end

        if (w_wr_snap[i]) r_snap[i] <= r_cnt[i];
      end
    end
  end

  assign irq     = r_to & r_ito;
  assign irq_any = |irq;

  // Read mux; unused bits and unmapped addresses return zero.
  always_comb begin
    w_rd = '0;
    if (w_glb) begin
      if (w_reg == 2'd1) w_rd[NUM_CH-1:0] = irq;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_ch == 3'(i)) begin
          case (w_reg)
            2'd0:    w_rd[1:0]       = {r_run[i], r_to[i]};
            2'd1:    w_rd[1:0]       = {r_cont[i], r_ito[i]};
            2'd2:    w_rd[CNT_W-1:0] = r_period[i];
            default: w_rd[CNT_W-1:0] = r_snap[i];
          endcase
        end
      end
    end
  end

  // Registered read data, one cycle after the address is presented.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_readdata <= '0;
    else          r_readdata <= w_rd;
  end

  assign readdata = r_readdata;

endmodule
